// File: rtl/control_pkg.sv
// control_pkg: state encoding, MIPS opcode/funct constants and datapath mux selects
// shared by the multi-cycle control FSM and its memory wait timer.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEM_TOREG_MDR    = 2'b01;
  localparam logic [1:0] MEM_TOREG_PC     = 2'b10;

  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG_A  = 2'b11;

  // States that stall on the memory handshake and are watched by the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/control_fsm_32_mem_wait_timer.sv
// mem_wait_timer: down-counter of consecutive stalled memory cycles; expired
// pulses on the MEM_TIMEOUT-th stalled cycle. MEM_TIMEOUT = 0 never expires.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wait_active,
  input  logic mem_ready,
  output logic expired
);

  localparam int unsigned W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(1);

  logic [W-1:0] remaining;
  logic         stalled;

  assign stalled = wait_active & ~mem_ready;

  // Leaving a wait state only happens on mem_ready, so reloading whenever not
  // stalled also covers the clear-on-state-change case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= LOAD;
    end else if (!stalled) begin
      remaining <= LOAD;
    end else if (remaining > LAST) begin
      remaining <= remaining - 1'b1;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && stalled && (remaining == LAST);

endmodule

// File: rtl/control_fsm_32.sv
// control_fsm_32: multi-cycle MIPS control FSM (fetch/decode/execute) with memory
// handshake, memory timeout and halt. Define CTRL_PERF_CNT_EN for cycle/instr counters.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4, wait for mem_ready
// DECODE   | compute branch target, dispatch on opcode/funct
// MEM_ADDR | effective address A + imm
// MEM_RD   | load read, wait for mem_ready
// MEM_WB   | write MDR to rt
// MEM_WR   | store write, wait for mem_ready
// EXEC     | R-type ALU operation
// ALU_WB   | write ALUOut to rd
// BRANCH   | compare A/B, conditional PC load
// JUMP     | PC <= jump target
// ADDI_EX  | A + sign-ext imm
// ADDI_WB  | write ALUOut to rt
// JAL      | PC <= jump target, $31 <= PC
// JR       | PC <= A
// HALT     | fatal error, outputs idle until reset
module control_fsm_32
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        branch_eq,
  output logic        iord,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_toreg,
  output logic [1:0]  reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        instr_done,
  output logic        err_illegal_opcode,
  output logic        err_mem_timeout,
  output logic [3:0]  state_dbg
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  logic   set_illegal;
  logic   set_timeout;
  logic   wait_active;
  logic   tmo_expired;

  assign wait_active = is_wait_state(state_q);
  assign state_dbg   = state_q;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wait_active (wait_active),
    .mem_ready   (mem_ready),
    .expired     (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= S_FETCH;
      err_illegal_opcode <= 1'b0;
      err_mem_timeout    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) err_illegal_opcode <= 1'b1;
      if (set_timeout) err_mem_timeout    <= 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_eq     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_toreg     = MEM_TOREG_ALUOUT;
    reg_dst       = REG_DST_RT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_REG;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_B_FOUR;
        // Mealy strobes are masked while reset is held so nothing is written.
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (tmo_expired) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end

      S_DECODE: begin
        alu_src_b = ALU_B_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_RTYPE:       state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDI_EX;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default: begin
            set_illegal = 1'b1;
            state_d     = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (tmo_expired) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_toreg  = MEM_TOREG_MDR;
        reg_dst    = REG_DST_RT;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (tmo_expired) begin
          state_d     = S_HALT;
          set_timeout = 1'b1;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_REG;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RD;
        mem_toreg  = MEM_TOREG_ALUOUT;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        state_d   = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RT;
        mem_toreg  = MEM_TOREG_ALUOUT;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALU_B_REG;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        branch_eq     = ~opcode[0];
        pc_source     = PC_SRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_toreg  = MEM_TOREG_PC;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JR: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_REG_A;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state_q != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done)        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_fsm_32.sv
// tb_control_fsm_32: randomized self-checking bench for control_fsm_32 with three
// parameterisations (default, MEM_TIMEOUT=4, ILLEGAL_HALT=0) sharing the stimulus.
module tb_control_fsm_32;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, JAL = 6'b000011, BAD = 6'b111111;
  localparam logic [5:0] F_JR = 6'b001000, F_ADD = 6'b100000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready;
  logic [5:0] opcode;
  logic [5:0] funct;

  logic       pc_write [3];
  logic       pc_write_cond [3];
  logic       branch_eq [3];
  logic       iord [3];
  logic       ir_write [3];
  logic       mem_read [3];
  logic       mem_write [3];
  logic [1:0] mem_toreg [3];
  logic [1:0] reg_dst [3];
  logic       reg_write [3];
  logic       alu_src_a [3];
  logic [1:0] alu_src_b [3];
  logic [1:0] alu_op [3];
  logic [1:0] pc_source [3];
  logic       instr_done [3];
  logic       err_illegal_opcode [3];
  logic       err_mem_timeout [3];
  logic [3:0] state_dbg [3];
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt [3];
  logic [31:0] instr_cnt [3];
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int st;
    bit rdy;
    bit done;
  } cyc_t;
  cyc_t exp_q[$];

  always #5 clk = ~clk;

  control_fsm_32 #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]), .branch_eq(branch_eq[0]),
    .iord(iord[0]), .ir_write(ir_write[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_toreg(mem_toreg[0]), .reg_dst(reg_dst[0]), .reg_write(reg_write[0]),
    .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
    .pc_source(pc_source[0]), .instr_done(instr_done[0]),
    .err_illegal_opcode(err_illegal_opcode[0]), .err_mem_timeout(err_mem_timeout[0]),
    .state_dbg(state_dbg[0])
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt[0]), .instr_cnt(instr_cnt[0])
`endif
  );

  control_fsm_32 #(.MEM_TIMEOUT(4), .ILLEGAL_HALT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]), .branch_eq(branch_eq[1]),
    .iord(iord[1]), .ir_write(ir_write[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_toreg(mem_toreg[1]), .reg_dst(reg_dst[1]), .reg_write(reg_write[1]),
    .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
    .pc_source(pc_source[1]), .instr_done(instr_done[1]),
    .err_illegal_opcode(err_illegal_opcode[1]), .err_mem_timeout(err_mem_timeout[1]),
    .state_dbg(state_dbg[1])
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt[1]), .instr_cnt(instr_cnt[1])
`endif
  );

  control_fsm_32 #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write[2]), .pc_write_cond(pc_write_cond[2]), .branch_eq(branch_eq[2]),
    .iord(iord[2]), .ir_write(ir_write[2]), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .mem_toreg(mem_toreg[2]), .reg_dst(reg_dst[2]), .reg_write(reg_write[2]),
    .alu_src_a(alu_src_a[2]), .alu_src_b(alu_src_b[2]), .alu_op(alu_op[2]),
    .pc_source(pc_source[2]), .instr_done(instr_done[2]),
    .err_illegal_opcode(err_illegal_opcode[2]), .err_mem_timeout(err_mem_timeout[2]),
    .state_dbg(state_dbg[2])
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt[2]), .instr_cnt(instr_cnt[2])
`endif
  );

  function automatic logic [19:0] act_vec(input int k);
    return {pc_write[k], pc_write_cond[k], branch_eq[k], iord[k], ir_write[k],
            mem_read[k], mem_write[k], mem_toreg[k], reg_dst[k], reg_write[k],
            alu_src_a[k], alu_src_b[k], alu_op[k], pc_source[k], instr_done[k]};
  endfunction

  // Output table per state, straight from the control-signal description.
  function automatic logic [19:0] exp_vec(input int st, input logic [5:0] op,
                                          input logic rdy, input bit done);
    logic pcw = 0, pwc = 0, beq = 0, io = 0, irw = 0, mr = 0, mw = 0, rw = 0, sa = 0;
    logic [1:0] mtr = 0, rd = 0, sb = 0, ao = 0, ps = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; mtr = 2'b01; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin sa = 1; ao = 2'b01; pwc = 1; beq = ~op[0]; ps = 2'b01; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; mtr = 2'b10; end
      13: begin pcw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pcw, pwc, beq, io, irw, mr, mw, mtr, rd, rw, sa, sb, ao, ps, logic'(done)};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input int st, input bit rdy, input bit done);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.done = done;
    exp_q.push_back(c);
  endtask

  // Reference sequence for one instruction: wf fetch stalls, wm data-memory stalls.
  task automatic build_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm);
    for (int i = 0; i < wf; i++) push(0, 0, 0);
    push(0, 1, 0);
    push(1, rb(), 0);
    if (op == LW) begin
      push(2, rb(), 0);
      for (int i = 0; i < wm; i++) push(3, 0, 0);
      push(3, 1, 0);
      push(4, rb(), 1);
    end else if (op == SW) begin
      push(2, rb(), 0);
      for (int i = 0; i < wm; i++) push(5, 0, 0);
      push(5, 1, 1);
    end else if (op == RT && fn == F_JR) begin
      push(13, rb(), 1);
    end else if (op == RT) begin
      push(6, rb(), 0);
      push(7, rb(), 1);
    end else if (op == BEQ || op == BNE) begin
      push(8, rb(), 1);
    end else if (op == ADDI) begin
      push(10, rb(), 0);
      push(11, rb(), 1);
    end else if (op == JMP) begin
      push(9, rb(), 1);
    end else if (op == JAL) begin
      push(12, rb(), 1);
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic run_seq(input int k, input string name);
    cyc_t c;
    int n = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      mem_ready = c.rdy;
      @(negedge clk);
      checks++;
      if (state_dbg[k] !== 4'(c.st)) begin
        failures++;
        $display("FAIL %s_state dut=%0d cycle=%0d got=%0d expected=%0d",
                 name, k, n, state_dbg[k], c.st);
      end
      checks++;
      if (act_vec(k) !== exp_vec(c.st, opcode, c.rdy, c.done)) begin
        failures++;
        $display("FAIL %s_outputs dut=%0d cycle=%0d state=%0d got=%05h expected=%05h",
                 name, k, n, c.st, act_vec(k), exp_vec(c.st, opcode, c.rdy, c.done));
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_errs(input int k, input logic ill, input logic tmo, input string name);
    checks++;
    if (err_illegal_opcode[k] !== ill || err_mem_timeout[k] !== tmo) begin
      failures++;
      $display("FAIL %s_errs dut=%0d got=%b%b expected=%b%b", name, k,
               err_illegal_opcode[k], err_mem_timeout[k], ill, tmo);
    end
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_in_reset(input string name);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (state_dbg[k] !== 4'd0 || act_vec(k) !== exp_vec(0, opcode, 1'b0, 0)) begin
        failures++;
        $display("FAIL %s dut=%0d got state=%0d outs=%05h expected state=0 outs=%05h",
                 name, k, state_dbg[k], act_vec(k), exp_vec(0, opcode, 1'b0, 0));
      end
      check_errs(k, 1'b0, 1'b0, name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mem_ready = 1'b0; opcode = LW; funct = 6'd0;
    #2 rst_n = 1'b0;
    #1 check_in_reset("por");
    do_reset();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_in_reset("mid_instr_reset");
    @(posedge clk); #1;
    check_in_reset("held_reset");
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    do_reset();
    opcode = LW; funct = 6'd0;
    build_instr(LW, 6'd0, 0, 0);
    run_seq(0, "lw");
    check_errs(0, 1'b0, 1'b0, "lw");
  endtask

  task automatic test_rtype_jr();
    do_reset();
    opcode = RT; funct = F_ADD;
    build_instr(RT, F_ADD, 0, 0);
    run_seq(0, "add");
    funct = F_JR;
    build_instr(RT, F_JR, 0, 0);
    run_seq(0, "jr");
  endtask

  task automatic test_branch();
    do_reset();
    opcode = BNE; funct = 6'd0;
    build_instr(BNE, 6'd0, 0, 0);
    run_seq(0, "bne");
    opcode = BEQ;
    build_instr(BEQ, 6'd0, 1, 0);
    run_seq(0, "beq");
  endtask

  task automatic test_sw_wait();
    do_reset();
    opcode = SW; funct = 6'd0;
    build_instr(SW, 6'd0, 0, 3);
    run_seq(0, "sw_wait");
    check_errs(0, 1'b0, 1'b0, "sw_wait");
  endtask

  task automatic test_long_wait();
    do_reset();
    opcode = LW; funct = 6'd0;
    build_instr(LW, 6'd0, 15, 15);
    run_seq(0, "lw_wait15");
    check_errs(0, 1'b0, 1'b0, "lw_wait15");
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] ic0;
`endif
    do_reset();
`ifdef CTRL_PERF_CNT_EN
    ic0 = instr_cnt[0];
`endif
    for (int i = 0; i < 40; i++) begin
      fn = 6'd0;
      case ($urandom_range(0, 8))
        0: op = LW;
        1: op = SW;
        2: begin
          op = RT;
          fn = 6'($urandom_range(0, 63));
          if (fn == F_JR) fn = F_ADD;
        end
        3: begin op = RT; fn = F_JR; end
        4: op = BEQ;
        5: op = BNE;
        6: op = ADDI;
        7: op = JMP;
        default: op = JAL;
      endcase
      opcode = op; funct = fn;
      build_instr(op, fn, $urandom_range(0, 5), $urandom_range(0, 5));
      run_seq(0, "random");
    end
    check_errs(0, 1'b0, 1'b0, "random");
`ifdef CTRL_PERF_CNT_EN
    checks++;
    if (instr_cnt[0] - ic0 !== 32'd40) begin
      failures++;
      $display("FAIL instr_cnt got=%0d expected=40", instr_cnt[0] - ic0);
    end
`endif
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = JMP; funct = 6'd0;
    build_instr(JMP, 6'd0, 3, 0);
    run_seq(1, "t4_three_waits");
    check_errs(1, 1'b0, 1'b0, "t4_three_waits");
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg[1] !== 4'd0 || ir_write[1] !== 1'b0) begin
        failures++;
        $display("FAIL t4_stall cycle=%0d got state=%0d ir_write=%b expected state=0 ir_write=0",
                 i, state_dbg[1], ir_write[1]);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg[1] !== 4'd15 || act_vec(1) !== 20'h0) begin
        failures++;
        $display("FAIL t4_halt cycle=%0d got state=%0d outs=%05h expected state=15 outs=00000",
                 i, state_dbg[1], act_vec(1));
      end
      check_errs(1, 1'b0, 1'b1, "t4_halt");
      @(posedge clk); #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (state_dbg[1] !== 4'd0) begin
      failures++;
      $display("FAIL t4_recover got state=%0d expected=0", state_dbg[1]);
    end
    check_errs(1, 1'b0, 1'b0, "t4_recover");
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = BAD; funct = 6'd0;
    build_instr(BAD, 6'd0, 0, 0);
    run_seq(0, "illegal_halt");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg[0] !== 4'd15 || act_vec(0) !== 20'h0) begin
        failures++;
        $display("FAIL illegal_halt_state got state=%0d outs=%05h expected state=15 outs=00000",
                 state_dbg[0], act_vec(0));
      end
      check_errs(0, 1'b1, 1'b0, "illegal_halt");
      @(posedge clk); #1;
    end

    do_reset();
    opcode = BAD;
    build_instr(BAD, 6'd0, 1, 0);
    run_seq(2, "illegal_return");
    check_errs(2, 1'b1, 1'b0, "illegal_return");
    opcode = LW;
    build_instr(LW, 6'd0, 0, 1);
    run_seq(2, "lw_after_illegal");
    check_errs(2, 1'b1, 1'b0, "lw_after_illegal");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_jr();
    test_branch();
    test_sw_wait();
    test_long_wait();
    test_back_to_back();
    test_timeout();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
